// File: rtl/anc_dac_out.sv
// anc_dac_out: rounds/saturates the LMS anti-noise output to Q15,
// buffers it in a small FIFO and plays it to the DAC with prime/run control.
module anc_dac_out #(
    parameter int DEPTH = 4,
    parameter int SHIFT = 15,
    parameter int PRIME = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [31:0]        in_sample,
    input  logic                      mute,
    input  logic                      clr_stats,
    input  logic                      dac_req,
    output logic signed [15:0]        dac_data,
    output logic                      dac_valid,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               sat_count,
    output logic [7:0]                ovf_count,
    output logic                      underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic signed [32:0]       w_sum;
    logic signed [32:0]       w_shr;
    logic signed [15:0]       w_clamp;
    logic                     w_sat;
    logic                     w_sat_inc;

    logic signed [15:0]       r_s1_data;
    logic                     r_s1_vld;

    logic signed [15:0]       r_mem [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [LW-1:0]            r_level;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_pop;
    logic                     w_urun;

    logic signed [15:0]       r_dac_data;
    logic                     r_dac_valid;
    logic [15:0]              r_sat_cnt;
    logic [7:0]               r_ovf_cnt;
    logic                     r_underrun;

    // Round half-up, arithmetic shift, clamp to the signed 16-bit range
    always_comb begin
        w_sum   = $signed({in_sample[31], in_sample}) + RND;
        w_shr   = w_sum >>> SHIFT;
        w_sat   = 1'b0;
        w_clamp = w_shr[15:0];
        if (w_shr > 33'sd32767) begin
            w_sat   = 1'b1;
            w_clamp = 16'sh7FFF;
        end else if (w_shr < -33'sd32768) begin
            w_sat   = 1'b1;
            w_clamp = 16'sh8000;
        end
    end

    // Muted samples are zero and never count as saturated
    assign w_sat_inc = in_valid && !mute && w_sat;

    // Stage-1 register: conditioned sample plus its valid bit
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_data <= mute ? 16'sd0 : w_clamp;
            end
        end
    end

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    // A same-cycle pop frees the slot the write needs
    assign w_push  = r_s1_vld && (!w_full || w_pop);
    assign w_drop  = r_s1_vld && w_full && !w_pop;

    // Prime/run next-state, pop and underrun decode
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_urun      = 1'b0;
        unique case (r_state)
            ST_PRIME: begin
                if (r_level >= LW'(PRIME)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dac_req) begin
                    if (w_empty) begin
                        w_urun      = 1'b1;
                        w_state_nxt = ST_PRIME;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_PRIME;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; stale contents are harmless once pointers reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s1_data;
        end
    end

    // FIFO pointers and registered occupancy
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // DAC output: zero while priming, head on pop, hold on underrun
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_dac_data  <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            r_dac_valid <= dac_req;
            if (dac_req) begin
                if (r_state == ST_PRIME) begin
                    r_dac_data <= '0;
                end else if (w_pop) begin
                    r_dac_data <= r_mem[r_rd_ptr];
                end
            end
        end
    end

    // Saturating statistics; a clear overrides any same-cycle event
    always_ff @(posedge clk) begin
        if (rst_n || clr_stats) begin
            r_sat_cnt  <= '0;
            r_ovf_cnt  <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_sat_inc && r_sat_cnt != 16'hFFFF) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
            if (w_drop && r_ovf_cnt != 8'hFF) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
            if (w_urun) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign dac_data   = r_dac_data;
    assign dac_valid  = r_dac_valid;
    assign fifo_level = r_level;
    assign sat_count  = r_sat_cnt;
    assign ovf_count  = r_ovf_cnt;
    assign underrun   = r_underrun;

endmodule

// File: doc/anc_dac_out.md
# anc_dac_out

Output conditioning stage placed directly downstream of the LMS top level. It takes the 32-bit anti-noise filter output (`out_sample`/`out_valid`), rounds and saturates it to 16 bits, and buffers it in a small FIFO. It then hands one sample per request to the DAC serializer. A prime/run state machine guarantees a minimum FIFO fill before playback and recovers cleanly from underruns.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `SHIFT`, default 15: arithmetic right shift applied to the input (Q30 to Q15); must be at least 1.
- `PRIME`, default 2: FIFO level required to leave PRIME; must satisfy 1 ≤ PRIME ≤ DEPTH.
- `clk` in 1: sole clock; all logic acts on the rising edge.
- `rst_n` in 1: synchronous, active-high reset; the name is kept for codebase consistency.
- `in_valid` in 1: `in_sample` is valid this cycle; this is the LMS `out_valid`.
- `in_sample` in 32 signed: LMS filter output.
- `mute` in 1: when high, sample values are forced to 0 before the FIFO.
- `clr_stats` in 1: one-cycle clear of `sat_count`, `ovf_count` and `underrun`.
- `dac_req` in 1: one-cycle strobe from the DAC serializer requesting the next sample.
- `dac_data` out 16 signed: sample delivered to the DAC.
- `dac_valid` out 1: one-cycle pulse; `dac_data` is valid.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `sat_count` out 16: count of saturated samples; sticks at 0xFFFF.
- `ovf_count` out 8: count of samples dropped on a full FIFO; sticks at 0xFF.
- `underrun` out 1: sticky flag; a request arrived in RUN while the FIFO was empty.

## Operation
- **Stage 1 (round/saturate), on `in_valid`:**
  - Sign-extend `in_sample` to 33 bits and add 1<<(SHIFT-1). This is round-half-up toward +inf.
  - Arithmetic-shift right by SHIFT.
  - Clamp to [-32768, 32767]. A clamp increments `sat_count`.
  - If `mute` is high, the stored value is 0 and saturation is not counted.
  - Result and a valid bit are registered into `s1_data`/`s1_vld`.
- **Stage 2 (FIFO write):**
  - When `s1_vld` is set and the FIFO is not full, write and advance the write pointer, which wraps modulo DEPTH.
  - When `s1_vld` is set and the FIFO is full, drop the sample and increment `ovf_count`. Exception: a pop in the same cycle frees a slot, so the write is accepted and nothing is dropped.
- **Read, on `dac_req`:** `dac_valid` pulses the next cycle in every state.
  - PRIME state: `dac_data` is 0, no pop, and no underrun is flagged.
  - RUN state, FIFO non-empty: pop the head into `dac_data`.
  - RUN state, FIFO empty: repeat the previous `dac_data`, set `underrun`, and move to PRIME. A write in the same cycle is not bypassed; it is stored.
- **State machine:**
  - PRIME → RUN when `fifo_level` ≥ PRIME, evaluated on the registered level.
  - RUN → PRIME on an underrun.
  - No other transitions.
- **Statistics:**
  - `clr_stats` wins over a simultaneous increment or underrun set; the result is 0.
  - Counters saturate; they never wrap.
- **`dac_req` timing:** `dac_req` pulses are at least one cycle apart. A `dac_req` that is held high is treated as one request per cycle.

## Timing
- **Reset values:**
  - `dac_data`=0, `dac_valid`=0, `fifo_level`=0, `sat_count`=0, `ovf_count`=0, `underrun`=0.
  - State=PRIME, pointers=0, `s1_vld`=0.
- **Reset asserted mid-operation:**
  - The FIFO contents are discarded and any in-flight `s1` sample is dropped.
  - A `dac_valid` pulse scheduled for the next cycle is suppressed.
- **Latency:**
  - `in_valid` at edge k is captured into `s1` at edge k.
  - The FIFO write occurs at edge k+1, and `fifo_level` shows it after edge k+1.
  - The earliest `dac_req` that can pop this sample is sampled at edge k+2. `dac_data`/`dac_valid` update at that same edge and are visible in cycle k+2.
- **Throughput:** one input per cycle and one output per cycle, sustained.
- **`fifo_level`:** registered; a simultaneous push and pop leave it unchanged.
- **State update:** the state register updates one edge after `fifo_level` reaches PRIME.

## Test plan
- **Rounding/saturation (SHIFT=15, `mute`=0)** — drive the following inputs, then drain with `dac_req`; `sat_count` must end at 2:
  - 0x00004000 → 1
  - 0xFFFFC000 → 0
  - 0x00007FFF → 1
  - 0x40000000 → 32767 (saturated)
  - 0x80000000 → -32768 (saturated)
- **Priming:** after reset, issue `dac_req` with an empty FIFO → `dac_valid` with data 0 and `underrun` stays 0. Push 2 samples (5, 6); the state reaches RUN; the next two requests → 5, then 6.
- **Underrun:** in RUN with the FIFO empty, `dac_req` → `dac_data` repeats 6, `underrun`=1, state=PRIME. `clr_stats` → `underrun`=0.
- **Overflow:** with DEPTH=4 and no requests, push 6 samples → `fifo_level`=4 and `ovf_count`=2. Push while `dac_req` is high on a full FIFO → no drop, level stays 4.
- **Mute and clear priority:** `mute`=1 with input 0x7FFFFFFF → output 0 and `sat_count` unchanged. `clr_stats` in the same cycle as a saturating sample → `sat_count`=0.
- **Reset mid-stream:** 3 samples buffered, a request pending, then `rst_n`=1 for one cycle → next cycle `dac_valid`=0, level 0, all statistics 0, state PRIME.
